// File: rtl/fsm_stim_player_if.sv
// rtl/fsm_stim_player_if.sv - player <-> FSM-under-test pin bundle (SW, KEY, LEDR)
interface fsm_stim_player_if;
  logic [1:0] sw;    // drives FSM SW
  logic [1:0] key;   // drives FSM KEY, active-low: [0] reset, [1] button
  logic [1:0] ledr;  // FSM LEDR response

  modport master (output sw, output key, input ledr);
  modport slave  (input sw, input key, output ledr);
endinterface

// File: rtl/fsm_stim_player.sv
// rtl/fsm_stim_player.sv - scripted SW/KEY stimulus player with LEDR capture; optional self-check via `PLAYER_CHECK_EN
module fsm_stim_player #(
  parameter int                 STEPS    = 4,
  parameter logic [2*STEPS-1:0] SCRIPT   = 8'b10_01_11_00,
  parameter int                 HOLD_CYC = 3,
  parameter int                 GAP_CYC  = 3,
  parameter logic [2*STEPS-1:0] EXP      = '0
) (
  input  logic               CLOCK_125_p,
  input  logic [1:0]         KEY,
  fsm_stim_player_if.master  fsm,
  output logic [2*STEPS-1:0] resp_o,
  output logic [1:0]         LEDR
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] LAST_STEP = IW'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETUP, S_PRESS, S_SAMPLE, S_DONE
  } state_t;

  logic rst_n;
  assign rst_n = KEY[0];

  logic btn_s1, btn_s2, btn_d;
  logic start;

  state_t            state_q, state_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic [IW-1:0]     step_q, step_nx;
  logic [1:0]        sw_q, sw_nx;
  logic [1:0]        key_q, key_nx;
  logic [2*STEPS-1:0] resp_q, resp_nx;
  logic [1:0]        ledr_q, ledr_nx;
`ifdef PLAYER_CHECK_EN
  logic              pass_nx;
`endif

  // Start button: two-flop synchronizer, then a registered copy for falling-edge detect.
  always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_d  <= 1'b1;
    end else begin
      btn_s1 <= KEY[1];
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign start = btn_d & ~btn_s2;

  // State register plus all registered outputs; nothing reaches a port combinationally.
  always_ff @(posedge CLOCK_125_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      sw_q    <= 2'b00;
      key_q   <= 2'b11;
      resp_q  <= '0;
      ledr_q  <= 2'b00;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      step_q  <= step_nx;
      sw_q    <= sw_nx;
      key_q   <= key_nx;
      resp_q  <= resp_nx;
      ledr_q  <= ledr_nx;
    end
  end

  // Next state and next output values; the counter is reloaded on every phase entry.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    step_nx  = step_q;
    sw_nx    = sw_q;
    key_nx   = 2'b11;
    resp_nx  = resp_q;
`ifdef PLAYER_CHECK_EN
    pass_nx  = ledr_q[1];
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_RST;
          cnt_nx   = HOLD_LD;
          step_nx  = '0;
          resp_nx  = '0;
          key_nx   = 2'b10;
`ifdef PLAYER_CHECK_EN
          pass_nx  = 1'b0;
`endif
        end
      end
      S_RST: begin
        if (cnt_q == '0) begin
          state_nx = S_SETUP;
          cnt_nx   = GAP_LD;
          sw_nx    = SCRIPT[2*int'(step_q) +: 2];
        end else begin
          cnt_nx = cnt_q - 1'b1;
          key_nx = 2'b10;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_nx = S_PRESS;
          cnt_nx   = HOLD_LD;
          key_nx   = 2'b01;
        end else begin
          cnt_nx = cnt_q - 1'b1;
        end
      end
      S_PRESS: begin
        if (cnt_q == '0) begin
          state_nx = S_SAMPLE;
          cnt_nx   = GAP_LD;
        end else begin
          cnt_nx = cnt_q - 1'b1;
          key_nx = 2'b01;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          resp_nx[2*int'(step_q) +: 2] = fsm.ledr;
          if (step_q == LAST_STEP) begin
            state_nx = S_DONE;
`ifdef PLAYER_CHECK_EN
            pass_nx  = (resp_nx == EXP);
`endif
          end else begin
            state_nx = S_SETUP;
            cnt_nx   = GAP_LD;
            step_nx  = step_q + 1'b1;
            sw_nx    = SCRIPT[2*int'(step_nx) +: 2];
          end
        end else begin
          cnt_nx = cnt_q - 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    ledr_nx[0] = (state_nx == S_DONE);
`ifdef PLAYER_CHECK_EN
    ledr_nx[1] = pass_nx;
`else
    ledr_nx[1] = (state_nx != S_IDLE) && (state_nx != S_DONE);
`endif
  end

  assign fsm.sw  = sw_q;
  assign fsm.key = key_q;
  assign resp_o  = resp_q;
  assign LEDR    = ledr_q;

endmodule

// File: tb/tb_fsm_stim_player.sv
// tb/tb_fsm_stim_player.sv - randomized self-checking bench for fsm_stim_player against a timeline model
module tb_fsm_stim_player;

  localparam int         STEPS  = 4;
  localparam logic [7:0] SCRIPT = 8'b10_01_11_00;
  localparam int         H      = 3;
  localparam int         G      = 3;
  localparam logic [7:0] EXP    = 8'h55;
  localparam int         P      = 2*G + H;
  localparam int         TOTAL  = H + STEPS*P;

  logic       clk = 1'b0;
  logic [1:0] KEY;
  logic [7:0] resp;
  logic [1:0] LEDR;

  fsm_stim_player_if fsm_bus ();

  fsm_stim_player #(
    .STEPS(STEPS), .SCRIPT(SCRIPT), .HOLD_CYC(H), .GAP_CYC(G), .EXP(EXP)
  ) dut (
    .CLOCK_125_p(clk),
    .KEY        (KEY),
    .fsm        (fsm_bus),
    .resp_o     (resp),
    .LEDR       (LEDR)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] v [STEPS];
  logic [1:0] prev_sw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] script_at(input int k);
    logic [7:0] s;
    s = SCRIPT;
    return s[2*k +: 2];
  endfunction

  function automatic logic [7:0] v_packed();
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < STEPS; k++) r[2*k +: 2] = v[k];
    return r;
  endfunction

  // Timeline model: t = 0 is the first cycle the FSM reset is held low.
  function automatic logic [1:0] exp_sw(input int t);
    int k;
    if (t < H) return prev_sw;
    k = (t - H) / P;
    if (k >= STEPS) k = STEPS - 1;
    return script_at(k);
  endfunction

  function automatic logic [1:0] exp_key(input int t);
    int p;
    if (t < H) return 2'b10;
    if (t >= TOTAL) return 2'b11;
    p = (t - H) % P;
    return (p >= G && p < G + H) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [7:0] exp_resp(input int t);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < STEPS; k++)
      if (t >= H + (k+1)*P) r[2*k +: 2] = v[k];
    return r;
  endfunction

  function automatic logic [1:0] exp_led(input int t);
    logic done;
    done = (t >= TOTAL);
`ifdef PLAYER_CHECK_EN
    return {done && (v_packed() == EXP), done};
`else
    return {~done, done};
`endif
  endfunction

  // Value presented on ledr for the edge that ends cycle t.
  function automatic logic [1:0] drive_ledr(input int mode, input int t, input logic [1:0] cur);
    int k, p;
    if (mode == 0) return 2'b01;
    if (mode == 3) return 2'b10;
    if (t >= H && t < TOTAL) begin
      k = (t - H) / P;
      p = (t - H) % P;
      if (p >= G + H) return v[k];
    end
    if (mode == 1) return cur;
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq(tag, {fsm_bus.sw, fsm_bus.key, resp, LEDR}, {2'b00, 2'b11, 8'h00, 2'b00});
  endtask

  // mode: 0 ledr=01, 1 ledr follows sw after each press, 2 random, 3 ledr=10
  task automatic run(input string name, input int mode, input int spam_at, input int abort_at);
    bit found;
    int lat;
    found = 0;
    lat   = 0;
    for (int k = 0; k < STEPS; k++) begin
      case (mode)
        0:       v[k] = 2'b01;
        1:       v[k] = script_at(k);
        3:       v[k] = 2'b10;
        default: v[k] = 2'($urandom_range(0, 3));
      endcase
    end
    fsm_bus.ledr = (mode == 3) ? 2'b10 : ((mode == 0) ? 2'b01 : 2'($urandom_range(0, 3)));

    @(posedge clk);
    #1 KEY[1] = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (i == 3) KEY[1] = 1'b1;
      if (fsm_bus.key[0] === 1'b0) begin
        found = 1;
        lat   = i;
      end
    end
    KEY[1] = 1'b1;
    check_eq({name, " start_latency_3_or_4"}, {31'd0, found && lat >= 3 && lat <= 4}, 32'd1);
    if (!found) return;

    for (int t = 0; t <= TOTAL + 4; t++) begin
      if (t == abort_at) begin
        KEY[0] = 1'b0;
        #1;
        check_reset_vals($sformatf("%s abort_immediate t=%0d", name, t));
        prev_sw = 2'b00;
        @(negedge clk);
        check_reset_vals({name, " abort_held"});
        KEY[0] = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_reset_vals({name, " abort_idle"});
        end
        return;
      end
      check_eq($sformatf("%s t=%0d sw", name, t),   fsm_bus.sw,  exp_sw(t));
      check_eq($sformatf("%s t=%0d key", name, t),  fsm_bus.key, exp_key(t));
      check_eq($sformatf("%s t=%0d resp", name, t), resp,        exp_resp(t));
      check_eq($sformatf("%s t=%0d ledr", name, t), LEDR,        exp_led(t));
      if (spam_at >= 0) begin
        if (t == spam_at)     KEY[1] = 1'b0;
        if (t == spam_at + 3) KEY[1] = 1'b1;
      end
      fsm_bus.ledr = drive_ledr(mode, t, fsm_bus.ledr);
      @(negedge clk);
    end
    prev_sw = script_at(STEPS - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    KEY          = 2'b10;
    fsm_bus.ledr = 2'b00;
    prev_sw      = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    KEY = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_reset_vals($sformatf("idle_no_start c=%0d", i));
    end

    run("const01", 0, -1, -1);
    check_eq("const01 final_resp", resp, 8'h55);
    run("moving", 1, -1, -1);
    check_eq("moving final_resp", resp, 8'b10_01_11_00);
    run("const10", 3, -1, -1);
    run("spam", 0, H + P + 1, -1);
    check_eq("spam final_resp", resp, 8'h55);
    run("abort", 2, -1, H + 2*P + 4);
    for (int r = 0; r < 4; r++) run($sformatf("rand%0d", r), 2, -1, -1);
    run("rerun01", 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
